// File: rtl/bp_fe_cmd_sched.sv
// Front-end command scheduler: a single redirect slot plus a small attaboy FIFO.
// The FIFO head overrides the redirect slot once it has been starved long enough.
module bp_fe_cmd_sched #(
   parameter int cmd_width_p    = 128,
   parameter int attaboy_els_p  = 4,
   parameter int starve_limit_p = 8
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic [cmd_width_p-1:0]                 cmd_i,
   input  logic                                   cmd_attaboy_i,
   input  logic                                   cmd_v_i,
   output logic                                   cmd_ready_and_o,
   output logic [cmd_width_p-1:0]                 cmd_o,
   output logic                                   cmd_v_o,
   input  logic                                   cmd_yumi_i,
   input  logic                                   attaboy_flush_i,
   output logic                                   attaboy_drop_o,
   output logic [$clog2(attaboy_els_p+1)-1:0]     attaboy_count_o
);

   localparam int PW = (attaboy_els_p > 1) ? $clog2(attaboy_els_p) : 1;
   localparam int CW = $clog2(attaboy_els_p + 1);
   localparam int SW = $clog2(starve_limit_p + 1);
   localparam logic [CW-1:0] FULL_CNT   = CW'(attaboy_els_p);
   localparam logic [SW-1:0] STARVE_MAX = SW'(starve_limit_p);

   logic                   slot_v_q, slot_v_d;
   logic [cmd_width_p-1:0] slot_q, slot_d;
   logic [cmd_width_p-1:0] mem_q [attaboy_els_p];
   logic [PW-1:0]          rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [SW-1:0]          starve_q, starve_d;
   logic                   drop_q, drop_d;

   logic fifo_v, sel_fifo, accept, enq_att, deq_fifo, deq_slot, full, overflow;

   always_comb begin
      fifo_v   = (cnt_q != {CW{1'b0}});
      sel_fifo = fifo_v & ((starve_q == STARVE_MAX) | ~slot_v_q);
      accept   = cmd_v_i & ~slot_v_q;
      enq_att  = accept & cmd_attaboy_i;
      deq_fifo = cmd_yumi_i & sel_fifo;
      deq_slot = cmd_yumi_i & ~sel_fifo & slot_v_q;
      full     = (cnt_q == FULL_CNT);
      // Overflow evicts the oldest attaboy; a flush or a same-cycle dequeue makes room instead.
      overflow = enq_att & full & ~deq_fifo & ~attaboy_flush_i;
   end

   always_comb begin
      slot_v_d = slot_v_q;
      slot_d   = slot_q;
      if (deq_slot) begin
         slot_v_d = 1'b0;
      end else if (accept & ~cmd_attaboy_i) begin
         slot_v_d = 1'b1;
         slot_d   = cmd_i;
      end else begin
         slot_v_d = slot_v_q;
      end
   end

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q + PW'(enq_att);
      cnt_d = cnt_q;
      if (attaboy_flush_i) begin
         rd_d  = wr_q;
         cnt_d = CW'(enq_att);
      end else begin
         rd_d = rd_q + PW'(deq_fifo | overflow);
         if (enq_att & ~deq_fifo & ~full) begin
            cnt_d = cnt_q + CW'(1);
         end else if (deq_fifo & ~enq_att) begin
            cnt_d = cnt_q - CW'(1);
         end else begin
            cnt_d = cnt_q;
         end
      end
   end

   always_comb begin
      drop_d = overflow;
      if (attaboy_flush_i | deq_fifo | ~fifo_v) begin
         starve_d = {SW{1'b0}};
      end else if (slot_v_q & (starve_q != STARVE_MAX)) begin
         starve_d = starve_q + SW'(1);
      end else begin
         starve_d = starve_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         slot_v_q <= 1'b0;
         slot_q   <= {cmd_width_p{1'b0}};
         rd_q     <= {PW{1'b0}};
         wr_q     <= {PW{1'b0}};
         cnt_q    <= {CW{1'b0}};
         starve_q <= {SW{1'b0}};
         drop_q   <= 1'b0;
      end else begin
         slot_v_q <= slot_v_d;
         slot_q   <= slot_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         drop_q   <= drop_d;
      end
   end

   // Storage carries no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk_i) begin
      if (enq_att & ~reset_i) begin
         mem_q[wr_q] <= cmd_i;
      end
   end

   assign cmd_ready_and_o = ~slot_v_q;
   assign cmd_v_o         = slot_v_q | fifo_v;
   assign cmd_o           = sel_fifo ? mem_q[rd_q] : slot_q;
   assign attaboy_drop_o  = drop_q;
   assign attaboy_count_o = cnt_q;

endmodule

// File: tb/tb_bp_fe_cmd_sched.sv
// Directed bench for bp_fe_cmd_sched with a queue-based reference model
// compared on every falling edge, plus hand-computed literal expectations.
module tb_bp_fe_cmd_sched;

   localparam int W   = 128;
   localparam int ELS = 4;
   localparam int LIM = 8;

   logic         clk = 1'b0;
   logic         reset_i, cmd_attaboy_i, cmd_v_i, cmd_yumi_i, attaboy_flush_i;
   logic [W-1:0] cmd_i;
   logic         cmd_ready_and_o, cmd_v_o, attaboy_drop_o;
   logic [W-1:0] cmd_o;
   logic [2:0]   attaboy_count_o;

   int n_cmp  = 0;
   int n_fail = 0;

   bit           m_slot_v;
   logic [W-1:0] m_slot;
   logic [W-1:0] m_q[$];
   int           m_starve;
   bit           m_drop;

   always #5 clk = ~clk;

   bp_fe_cmd_sched #(.cmd_width_p(W), .attaboy_els_p(ELS), .starve_limit_p(LIM)) dut (
      .clk_i(clk), .reset_i(reset_i), .cmd_i(cmd_i), .cmd_attaboy_i(cmd_attaboy_i),
      .cmd_v_i(cmd_v_i), .cmd_ready_and_o(cmd_ready_and_o), .cmd_o(cmd_o), .cmd_v_o(cmd_v_o),
      .cmd_yumi_i(cmd_yumi_i), .attaboy_flush_i(attaboy_flush_i),
      .attaboy_drop_o(attaboy_drop_o), .attaboy_count_o(attaboy_count_o));

   function automatic bit m_sel_fifo();
      return (m_q.size() > 0) && ((m_starve == LIM) || !m_slot_v);
   endfunction

   function automatic bit m_v();
      return m_slot_v || (m_q.size() > 0);
   endfunction

   task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Spec-level behaviour of one clock edge given the held inputs.
   task automatic model_step(input bit v, att, input logic [W-1:0] d, input bit y, fl, rs);
      bit sel, old_slot_v, old_fifo_v, acc;
      if (rs) begin
         m_slot_v = 1'b0; m_q.delete(); m_starve = 0; m_drop = 1'b0;
         return;
      end
      sel        = m_sel_fifo();
      old_slot_v = m_slot_v;
      old_fifo_v = (m_q.size() > 0);
      acc        = v && !m_slot_v;
      m_drop     = 1'b0;
      if (y && !sel) m_slot_v = 1'b0;
      if (y && sel) void'(m_q.pop_front());
      if (fl) m_q.delete();
      if (acc && !att) begin
         m_slot_v = 1'b1; m_slot = d;
      end
      if (acc && att) begin
         if (m_q.size() == ELS) begin
            void'(m_q.pop_front());
            m_drop = 1'b1;
         end
         m_q.push_back(d);
      end
      if (fl || (y && sel) || !old_fifo_v) m_starve = 0;
      else if (old_slot_v && m_starve < LIM) m_starve++;
   endtask

   task automatic compare_all();
      check("ready", {127'd0, cmd_ready_and_o}, {127'd0, !m_slot_v});
      check("valid", {127'd0, cmd_v_o}, {127'd0, m_v()});
      check("count", {125'd0, attaboy_count_o}, W'(m_q.size()));
      check("drop",  {127'd0, attaboy_drop_o}, {127'd0, m_drop});
      if (m_v()) check("cmd", cmd_o, m_sel_fifo() ? m_q[0] : m_slot);
   endtask

   // Hold inputs across one rising edge, step the model, then compare on the falling edge.
   task automatic cyc(input bit v, att, input logic [W-1:0] d, input bit y, fl, rs);
      if (y && !m_v()) begin
         n_cmp++; n_fail++;
         $display("FAIL yumi_legal: yumi driven with expected cmd_v_o 0 at %0t", $time);
      end
      cmd_v_i = v; cmd_attaboy_i = att; cmd_i = d;
      cmd_yumi_i = y; attaboy_flush_i = fl; reset_i = rs;
      @(posedge clk);
      model_step(v, att, d, y, fl, rs);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic att(input logic [W-1:0] d);
      cyc(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic redir(input logic [W-1:0] d);
      cyc(1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic yumi();
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      m_slot_v = 1'b0; m_slot = '0; m_starve = 0; m_drop = 1'b0;
      cyc(1'b1, 1'b1, 128'hBAD, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      check("rst_v", {127'd0, cmd_v_o}, 128'd0);
      check("rst_ready", {127'd0, cmd_ready_and_o}, 128'd1);
      check("rst_count", {125'd0, attaboy_count_o}, 128'd0);

      // Redirect latency and ready release.
      redir(128'hA001);
      check("r_v", {127'd0, cmd_v_o}, 128'd1);
      check("r_cmd", cmd_o, 128'hA001);
      check("r_ready0", {127'd0, cmd_ready_and_o}, 128'd0);
      yumi();
      check("r_ready1", {127'd0, cmd_ready_and_o}, 128'd1);

      // Overflow: five attaboys into a four-deep FIFO.
      for (int i = 0; i < 4; i++) att(128'hB000 + W'(i));
      check("ovf_pre_drop", {127'd0, attaboy_drop_o}, 128'd0);
      att(128'hB004);
      check("ovf_count", {125'd0, attaboy_count_o}, 128'd4);
      check("ovf_drop", {127'd0, attaboy_drop_o}, 128'd1);
      check("ovf_head", cmd_o, 128'hB001);

      // Full FIFO with simultaneous enqueue and dequeue.
      cyc(1'b1, 1'b1, 128'hB005, 1'b1, 1'b0, 1'b0);
      check("fd_drop", {127'd0, attaboy_drop_o}, 128'd0);
      check("fd_count", {125'd0, attaboy_count_o}, 128'd4);
      for (int i = 2; i <= 5; i++) begin
         check("fd_order", cmd_o, 128'hB000 + W'(i));
         yumi();
      end
      check("fd_empty", {127'd0, cmd_v_o}, 128'd0);

      // Starvation: slot R, FIFO {A}, yumi withheld eight cycles.
      att(128'hC006);
      redir(128'hA002);
      for (int i = 0; i < 7; i++) idle();
      check("st7_cmd", cmd_o, 128'hA002);
      idle();
      check("st8_cmd", cmd_o, 128'hC006);
      yumi();
      check("st_after_cmd", cmd_o, 128'hA002);
      check("st_after_cnt", {125'd0, attaboy_count_o}, 128'd0);
      yumi();

      // Back-to-back redirects need a bubble.
      redir(128'hA003);
      cyc(1'b1, 1'b0, 128'hA004, 1'b1, 1'b0, 1'b0);
      check("bub_v", {127'd0, cmd_v_o}, 128'd0);
      check("bub_ready", {127'd0, cmd_ready_and_o}, 128'd1);
      redir(128'hA004);
      check("bub_cmd", cmd_o, 128'hA004);
      yumi();

      // Flush with a same-cycle attaboy, then flush with the slot occupied.
      att(128'hD000);
      att(128'hD001);
      cyc(1'b1, 1'b1, 128'hD002, 1'b0, 1'b1, 1'b0);
      check("fl_count", {125'd0, attaboy_count_o}, 128'd1);
      check("fl_head", cmd_o, 128'hD002);
      redir(128'hA005);
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("fl_slot_cmd", cmd_o, 128'hA005);
      check("fl_slot_cnt", {125'd0, attaboy_count_o}, 128'd0);
      yumi();
      att(128'hD003);
      att(128'hD004);
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      check("fly_count", {125'd0, attaboy_count_o}, 128'd0);
      check("fly_v", {127'd0, cmd_v_o}, 128'd0);

      // Mixed traffic.
      for (int i = 0; i < 16; i++)
         cyc(1'b1, (i % 3) != 0, 128'hE000 + W'(i), m_v() && (i % 2 == 1), i == 11, 1'b0);

      // Reset with slot full and three attaboys, then immediate accept.
      while (m_v()) yumi();
      att(128'hF000); att(128'hF001); att(128'hF002);
      redir(128'hA006);
      cyc(1'b1, 1'b1, 128'hF003, 1'b0, 1'b0, 1'b1);
      check("rs_v", {127'd0, cmd_v_o}, 128'd0);
      check("rs_count", {125'd0, attaboy_count_o}, 128'd0);
      check("rs_ready", {127'd0, cmd_ready_and_o}, 128'd1);
      att(128'hF004);
      check("rs_accept", cmd_o, 128'hF004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
